vram_arbiter: RTL and testbench

//   Shares the single-port 16-bit VRAM between VGA scanout (read-only, hard real-time) and the Hack
//   CPU memory-mapped screen port (read/write). VGA has absolute priority. CPU writes are posted

---
 rtl/vram_arbiter.sv | 152 +++++++++++++++
 tb/tb_vram_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scanout has absolute priority, CPU writes are posted into a
// one-entry write buffer, and CPU reads either forward from that buffer or wait for a free slot.
module vram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] GNT_IDLE  = 2'd0;
    localparam logic [1:0] GNT_VGA   = 2'd1;
    localparam logic [1:0] GNT_WB    = 2'd2;
    localparam logic [1:0] GNT_CPURD = 2'd3;

    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_cpu_ack;
    logic              r_cpu_rd_ram;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_vga_valid;
    logic [DATA_W-1:0] r_vga_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    logic [1:0]        w_grant;
    logic              w_cpu_elig;
    logic              w_wb_hit;
    logic              w_wr_accept;
    logic              w_hit_accept;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_wdata;

    // The request seen during the ack cycle belongs to the next transaction, so it waits a cycle.
    assign w_cpu_elig   = cpu_req && !r_cpu_ack;
    assign w_wb_hit     = r_wb_valid && (r_wb_addr == cpu_addr);
    assign w_wr_accept  = w_cpu_elig && cpu_we && (!r_wb_valid || (w_grant == GNT_WB));
    assign w_hit_accept = w_cpu_elig && !cpu_we && w_wb_hit;

    // Slot grant: VGA, then buffer drain, then a CPU read miss.
    always_comb begin
        w_grant = GNT_IDLE;
        if (vga_req) begin
            w_grant = GNT_VGA;
        end else if (r_wb_valid) begin
            w_grant = GNT_WB;
        end else if (w_cpu_elig && !cpu_we) begin
            w_grant = GNT_CPURD;
        end else begin
            w_grant = GNT_IDLE;
        end
    end

    // RAM port drive for the granted requester; idle cycles hold the last address and data.
    always_comb begin
        w_ram_addr  = r_ram_addr;
        w_ram_we    = 1'b0;
        w_ram_wdata = r_ram_wdata;
        case (w_grant)
            GNT_VGA: begin
                w_ram_addr = vga_addr;
            end
            GNT_WB: begin
                w_ram_addr  = r_wb_addr;
                w_ram_we    = 1'b1;
                w_ram_wdata = r_wb_data;
            end
            GNT_CPURD: begin
                w_ram_addr = cpu_addr;
            end
            default: begin
                w_ram_addr  = r_ram_addr;
                w_ram_we    = 1'b0;
                w_ram_wdata = r_ram_wdata;
            end
        endcase
    end

    // Write buffer: a write accepted in a drain cycle reloads it, so the new data wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= {ADDR_W{1'b0}};
            r_wb_data  <= {DATA_W{1'b0}};
        end else if (w_wr_accept) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= cpu_addr;
            r_wb_data  <= cpu_wdata;
        end else if (w_grant == GNT_WB) begin
            r_wb_valid <= 1'b0;
        end
    end

    // CPU handshake and read data; a RAM read result is captured during its ack cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cpu_ack    <= 1'b0;
            r_cpu_rd_ram <= 1'b0;
            r_cpu_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_cpu_ack    <= w_wr_accept || w_hit_accept || (w_grant == GNT_CPURD);
            r_cpu_rd_ram <= (w_grant == GNT_CPURD);
            if (w_hit_accept) begin
                r_cpu_rdata <= r_wb_data;
            end else if (r_cpu_rd_ram) begin
                r_cpu_rdata <= ram_rdata;
            end
        end
    end

    // VGA return path and held RAM port values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vga_valid <= 1'b0;
            r_vga_rdata <= {DATA_W{1'b0}};
            r_ram_addr  <= {ADDR_W{1'b0}};
            r_ram_wdata <= {DATA_W{1'b0}};
        end else begin
            r_vga_valid <= vga_req;
            if (r_vga_valid) begin
                r_vga_rdata <= ram_rdata;
            end
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
        end
    end

    assign vga_valid = r_vga_valid;
    assign vga_rdata = r_vga_valid ? ram_rdata : r_vga_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rd_ram ? ram_rdata : r_cpu_rdata;
    assign ram_addr  = w_ram_addr;
    assign ram_we    = w_ram_we;
    assign ram_wdata = w_ram_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle vector table with a behavioural VRAM, plus
// hand-written reset sequences.
module tb_vram_arbiter;

    logic        clk;
    logic        resetn;
    logic        vga_req;
    logic [13:0] vga_addr;
    logic        vga_valid;
    logic [15:0] vga_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:16383];

    int n_pass;
    int n_total;

    typedef struct packed {
        logic        vga_req;
        logic [13:0] vga_addr;
        logic        cpu_req;
        logic        cpu_we;
        logic [13:0] cpu_addr;
        logic [15:0] cpu_wdata;
        logic        e_vv;
        logic [15:0] e_vrd;
        logic        e_ack;
        logic        chk_crd;
        logic [15:0] e_crd;
        logic        e_we;
        logic [13:0] e_addr;
        logic [15:0] e_wd;
    } vec_t;

    vec_t vec [0:24];

    vram_arbiter #(.ADDR_W(14), .DATA_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural VRAM with one cycle of registered read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_in(input logic vr, input logic [13:0] va, input logic cr, input logic cw,
                          input logic [13:0] ca, input logic [15:0] cd);
        vga_req = vr; vga_addr = va; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 16384; i++) mem[i] <= 16'h0000;
        mem[14'h0010] <= 16'h1111;
        mem[14'h0011] <= 16'h2222;
        mem[14'h0012] <= 16'h3333;
        mem[14'h0100] <= 16'h5A5A;

        //          vr   vaddr     cr   cw   caddr     cwdata    vv   vrd       ack  chk  crd       we   addr      wd
        vec[0]  = '{1'b1,14'h0010, 1'b0,1'b0,14'h0000, 16'h0000, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0010, 16'h0000};
        vec[1]  = '{1'b1,14'h0011, 1'b0,1'b0,14'h0000, 16'h0000, 1'b1,16'h1111, 1'b0,1'b0,16'h0000, 1'b0,14'h0011, 16'h0000};
        vec[2]  = '{1'b1,14'h0012, 1'b0,1'b0,14'h0000, 16'h0000, 1'b1,16'h2222, 1'b0,1'b0,16'h0000, 1'b0,14'h0012, 16'h0000};
        vec[3]  = '{1'b0,14'h0000, 1'b0,1'b0,14'h0000, 16'h0000, 1'b1,16'h3333, 1'b0,1'b0,16'h0000, 1'b0,14'h0012, 16'h0000};
        vec[4]  = '{1'b1,14'h0020, 1'b1,1'b1,14'h1234, 16'hBEEF, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0020, 16'h0000};
        vec[5]  = '{1'b1,14'h0021, 1'b0,1'b0,14'h0000, 16'h0000, 1'b1,16'h0000, 1'b1,1'b0,16'h0000, 1'b0,14'h0021, 16'h0000};
        vec[6]  = '{1'b1,14'h0022, 1'b1,1'b0,14'h1234, 16'h0000, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0022, 16'h0000};
        vec[7]  = '{1'b1,14'h0023, 1'b0,1'b0,14'h0000, 16'h0000, 1'b1,16'h0000, 1'b1,1'b1,16'hBEEF, 1'b0,14'h0023, 16'h0000};
        vec[8]  = '{1'b0,14'h0000, 1'b0,1'b0,14'h0000, 16'h0000, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 1'b1,14'h1234, 16'hBEEF};
        vec[9]  = '{1'b0,14'h0000, 1'b0,1'b0,14'h0000, 16'h0000, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h1234, 16'h0000};
        vec[10] = '{1'b1,14'h0030, 1'b1,1'b0,14'h0100, 16'h0000, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0030, 16'h0000};
        vec[11] = '{1'b0,14'h0000, 1'b1,1'b0,14'h0100, 16'h0000, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0100, 16'h0000};
        vec[12] = '{1'b1,14'h0031, 1'b0,1'b0,14'h0000, 16'h0000, 1'b0,16'h0000, 1'b1,1'b1,16'h5A5A, 1'b0,14'h0031, 16'h0000};
        vec[13] = '{1'b0,14'h0000, 1'b0,1'b0,14'h0000, 16'h0000, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0031, 16'h0000};
        vec[14] = '{1'b0,14'h0000, 1'b1,1'b1,14'h0200, 16'hAAAA, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0031, 16'h0000};
        vec[15] = '{1'b0,14'h0000, 1'b1,1'b1,14'h0201, 16'hBBBB, 1'b0,16'h0000, 1'b1,1'b0,16'h0000, 1'b1,14'h0200, 16'hAAAA};
        vec[16] = '{1'b0,14'h0000, 1'b1,1'b1,14'h0201, 16'hBBBB, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0200, 16'h0000};
        vec[17] = '{1'b0,14'h0000, 1'b0,1'b0,14'h0000, 16'h0000, 1'b0,16'h0000, 1'b1,1'b0,16'h0000, 1'b1,14'h0201, 16'hBBBB};
        vec[18] = '{1'b0,14'h0000, 1'b0,1'b0,14'h0000, 16'h0000, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0201, 16'h0000};
        vec[19] = '{1'b1,14'h0040, 1'b1,1'b1,14'h0300, 16'h1111, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0040, 16'h0000};
        vec[20] = '{1'b1,14'h0041, 1'b1,1'b1,14'h0301, 16'h2222, 1'b1,16'h0000, 1'b1,1'b0,16'h0000, 1'b0,14'h0041, 16'h0000};
        vec[21] = '{1'b1,14'h0042, 1'b1,1'b1,14'h0301, 16'h2222, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0042, 16'h0000};
        vec[22] = '{1'b0,14'h0000, 1'b1,1'b1,14'h0301, 16'h2222, 1'b1,16'h0000, 1'b0,1'b0,16'h0000, 1'b1,14'h0300, 16'h1111};
        vec[23] = '{1'b0,14'h0000, 1'b0,1'b0,14'h0000, 16'h0000, 1'b0,16'h0000, 1'b1,1'b0,16'h0000, 1'b1,14'h0301, 16'h2222};
        vec[24] = '{1'b0,14'h0000, 1'b0,1'b0,14'h0000, 16'h0000, 1'b0,16'h0000, 1'b0,1'b0,16'h0000, 1'b0,14'h0301, 16'h0000};

        resetn = 1'b0;
        set_in(1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        #2;
        chk("rst vga_valid", {31'd0, vga_valid}, 32'd0);
        chk("rst vga_rdata", {16'd0, vga_rdata}, 32'd0);
        chk("rst cpu_ack",   {31'd0, cpu_ack},   32'd0);
        chk("rst cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst ram_addr",  {18'd0, ram_addr},  32'd0);
        chk("rst ram_we",    {31'd0, ram_we},    32'd0);
        chk("rst ram_wdata", {16'd0, ram_wdata}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #3;
            chk($sformatf("idle%0d ram_we", i), {31'd0, ram_we}, 32'd0);
            chk($sformatf("idle%0d cpu_ack", i), {31'd0, cpu_ack}, 32'd0);
        end

        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            set_in(vec[i].vga_req, vec[i].vga_addr, vec[i].cpu_req, vec[i].cpu_we,
                   vec[i].cpu_addr, vec[i].cpu_wdata);
            #2;
            chk($sformatf("v%0d vga_valid", i), {31'd0, vga_valid}, {31'd0, vec[i].e_vv});
            chk($sformatf("v%0d cpu_ack", i),   {31'd0, cpu_ack},   {31'd0, vec[i].e_ack});
            chk($sformatf("v%0d ram_we", i),    {31'd0, ram_we},    {31'd0, vec[i].e_we});
            chk($sformatf("v%0d ram_addr", i),  {18'd0, ram_addr},  {18'd0, vec[i].e_addr});
            if (vec[i].e_vv)
                chk($sformatf("v%0d vga_rdata", i), {16'd0, vga_rdata}, {16'd0, vec[i].e_vrd});
            if (vec[i].chk_crd)
                chk($sformatf("v%0d cpu_rdata", i), {16'd0, cpu_rdata}, {16'd0, vec[i].e_crd});
            if (vec[i].e_we)
                chk($sformatf("v%0d ram_wdata", i), {16'd0, ram_wdata}, {16'd0, vec[i].e_wd});
        end
        @(posedge clk);
        #3;
        chk("mem 1234", {16'd0, mem[14'h1234]}, 32'h0000BEEF);
        chk("mem 0200", {16'd0, mem[14'h0200]}, 32'h0000AAAA);
        chk("mem 0201", {16'd0, mem[14'h0201]}, 32'h0000BBBB);
        chk("mem 0300", {16'd0, mem[14'h0300]}, 32'h00001111);
        chk("mem 0301", {16'd0, mem[14'h0301]}, 32'h00002222);

        // Buffered write discarded by reset.
        @(posedge clk);
        #1 set_in(1'b1, 14'h0050, 1'b1, 1'b1, 14'h0400, 16'hB0B0);
        #2 chk("wbrst accept ack", {31'd0, cpu_ack}, 32'd0);
        @(posedge clk);
        #1 set_in(1'b1, 14'h0051, 1'b0, 1'b0, 14'h0000, 16'h0000);
        #2 chk("wbrst ack", {31'd0, cpu_ack}, 32'd1);
        chk("wbrst no drain", {31'd0, ram_we}, 32'd0);
        #1 resetn = 1'b0;
        set_in(1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #3;
            chk($sformatf("wbrst%0d ram_we", i), {31'd0, ram_we}, 32'd0);
            chk($sformatf("wbrst%0d cpu_ack", i), {31'd0, cpu_ack}, 32'd0);
        end
        chk("wbrst mem 0400", {16'd0, mem[14'h0400]}, 32'd0);

        // Reset while a read miss is in flight: no ack may follow.
        @(posedge clk);
        #1 set_in(1'b0, 14'h0000, 1'b1, 1'b0, 14'h0100, 16'h0000);
        #2 chk("rdrst grant addr", {18'd0, ram_addr}, 32'h00000100);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 set_in(1'b0, 14'h0000, 1'b0, 1'b0, 14'h0000, 16'h0000);
        @(posedge clk);
        #1 resetn = 1'b1;
        #2 chk("rdrst ack0", {31'd0, cpu_ack}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #3 chk($sformatf("rdrst%0d ack", i), {31'd0, cpu_ack}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
